block_serial_subtractor: RTL
============================

BLOCK_SERIAL_SUBTRACTOR -- requirements
Module: block_serial_subtractor

Interface
REQ-001 Parameter WIDTH, default 16, operand and result width in bits.
REQ-002 Parameter BLOCK_SIZE, default 4, bits processed per RUN cycle; WIDTH not a multiple of BLOCK_SIZE SHALL cause an elaboration error.
REQ-003 Derived constant NBLK = WIDTH/BLOCK_SIZE; CW = $clog2(NBLK+1).
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 in_valid  input  1  operands A, B, Bin are valid.
REQ-007 in_ready  output  1  block can accept operands; high only in IDLE.
REQ-008 A  input  WIDTH  minuend, unsigned.
REQ-009 B  input  WIDTH  subtrahend, unsigned.
REQ-010 Bin  input  1  borrow-in.
REQ-011 out_valid  output  1  Diff, Bout, Bypass_cnt valid; high only in DONE.
REQ-012 out_ready  input  1  consumer accepts result.
REQ-013 Diff  output  WIDTH  registered (A - B - Bin) mod 2^WIDTH.
REQ-014 Bout  output  1  registered borrow-out; 1 iff A < B + Bin.
REQ-015 Bypass_cnt  output  CW  registered count of blocks whose borrow was bypassed.

Function
REQ-016 FSM states SHALL be IDLE, RUN, DONE.
REQ-017 IDLE: on in_valid & in_ready, latch A, B, Bin, clear Diff and Bypass_cnt, set block index 0, go to RUN; otherwise stay in IDLE.
REQ-018 RUN: each cycle, process block index i (bits i*BLOCK_SIZE+BLOCK_SIZE-1 .. i*BLOCK_SIZE) using the running borrow, write that slice of Diff, update the running borrow, increment i.
REQ-019 Block borrow-out SHALL equal the block borrow-in (bypass) when the A and B slices are equal; otherwise it SHALL be the ripple borrow of the slice; Bypass_cnt increments by 1 for each bypassed block.
REQ-020 After processing block NBLK-1, the FSM SHALL go to DONE with Bout = the final borrow.
REQ-021 Latency: operands accepted at edge k, out_valid high after edge k+NBLK (4 cycles at defaults).
REQ-022 DONE: Diff, Bout, Bypass_cnt held stable while out_valid & !out_ready; on out_ready go to IDLE on the next edge.
REQ-023 in_valid during RUN or DONE SHALL be ignored, and changes on A/B/Bin after acceptance SHALL NOT affect the result.
REQ-024 No new operands are accepted in the cycle DONE exits; the minimum initiation interval is NBLK+2 cycles.
REQ-025 in_ready and out_valid SHALL be decoded from the state register only, with no combinational path from in_valid or out_ready.

Reset
REQ-026 rst SHALL force IDLE on the next edge from any state, including mid-RUN, and abandon any partial result.
REQ-027 After reset, Diff, Bout, Bypass_cnt, the latched operands, the block index and the running borrow SHALL be 0, with out_valid=0 and in_ready=1.
REQ-028 rst SHALL take priority over in_valid and out_ready in the same cycle.

Structure
REQ-029 Shared package block_serial_subtractor_pkg SHALL hold the state enum type (IDLE, RUN, DONE).
REQ-030 One sub-module block_sub SHALL implement the combinational BLOCK_SIZE-bit slice subtractor: inputs a, b, bin; outputs d, bout, bypass.
REQ-031 The top level SHALL hold the FSM, the operand and result registers, the block index counter and slice muxing.

Verification
REQ-032 A=5678h, B=1234h, Bin=0 -> Diff=4444h, Bout=0, Bypass_cnt=0, out_valid 4 cycles after acceptance.
REQ-033 A=0000h, B=0001h, Bin=0 -> Diff=FFFFh, Bout=1, Bypass_cnt=3.
REQ-034 A=AAAAh, B=AAAAh, Bin=1 -> Diff=FFFFh, Bout=1, Bypass_cnt=4.
REQ-035 A=F000h, B=0FFFh, Bin=0, out_ready held low 3 cycles in DONE -> Diff=E001h, Bout=0, Bypass_cnt=0, outputs stable throughout the stall; in_ready stays 0 and a toggling in_valid with new A/B has no effect.
REQ-036 rst asserted during the 2nd RUN cycle -> next cycle IDLE, in_ready=1, out_valid=0, Diff=0; a following operation A=5678h, B=1234h, Bin=0 -> Diff=4444h.
REQ-037 Back-to-back operations with out_ready=1 -> second acceptance no earlier than NBLK+2 cycles after the first; a scoreboard checks both results against A-B-Bin.

Source files
------------

// File: rtl/block_serial_subtractor_pkg.sv
// Shared types for the block-serial subtractor: FSM state encoding.
package block_serial_subtractor_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/block_serial_subtractor_block_sub.sv
// Combinational BLOCK_SIZE-bit slice subtractor with borrow bypass when
// the two slices are equal.
module block_sub #(
    parameter int BLOCK_SIZE = 4
) (
    input  logic [BLOCK_SIZE-1:0] a,
    input  logic [BLOCK_SIZE-1:0] b,
    input  logic                  bin,
    output logic [BLOCK_SIZE-1:0] d,
    output logic                  bout,
    output logic                  bypass
);

    logic [BLOCK_SIZE:0] ripple_s;

    // Extended subtraction: the top bit of the (BLOCK_SIZE+1)-bit result is the ripple borrow
    always_comb begin
        ripple_s = {1'b0, a} - {1'b0, b} - {{BLOCK_SIZE{1'b0}}, bin};
        d        = ripple_s[BLOCK_SIZE-1:0];
        bypass   = (a == b);
        if (bypass) begin
            bout = bin;
        end else begin
            bout = ripple_s[BLOCK_SIZE];
        end
    end

endmodule

// File: rtl/block_serial_subtractor.sv
// Block-serial unsigned subtractor: accepts A, B, Bin in IDLE, processes one
// BLOCK_SIZE slice per RUN cycle, and presents Diff/Bout/Bypass_cnt in DONE.
module block_serial_subtractor
    import block_serial_subtractor_pkg::*;
#(
    parameter  int WIDTH      = 16,
    parameter  int BLOCK_SIZE = 4,
    localparam int NBLK       = WIDTH / BLOCK_SIZE,
    localparam int CW         = $clog2(NBLK + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Diff,
    output logic             Bout,
    output logic [CW-1:0]    Bypass_cnt
);

    if ((WIDTH % BLOCK_SIZE) != 32'sd0) begin : g_bad_cfg
        $error("block_serial_subtractor: WIDTH must be a multiple of BLOCK_SIZE");
    end

    localparam logic [CW-1:0] LAST_BLK = CW'(NBLK - 1);

    state_t                  state_r;
    logic [WIDTH-1:0]        a_r;
    logic [WIDTH-1:0]        b_r;
    logic                    borrow_r;
    logic [CW-1:0]           idx_r;
    logic [WIDTH-1:0]        diff_r;
    logic                    bout_r;
    logic [CW-1:0]           bypass_cnt_r;

    logic [BLOCK_SIZE-1:0]   a_slice_s;
    logic [BLOCK_SIZE-1:0]   b_slice_s;
    logic [BLOCK_SIZE-1:0]   d_slice_s;
    logic                    blk_bout_s;
    logic                    blk_bypass_s;

    assign a_slice_s = a_r[int'(idx_r) * BLOCK_SIZE +: BLOCK_SIZE];
    assign b_slice_s = b_r[int'(idx_r) * BLOCK_SIZE +: BLOCK_SIZE];

    block_sub #(
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_block_sub (
        .a      (a_slice_s),
        .b      (b_slice_s),
        .bin    (borrow_r),
        .d      (d_slice_s),
        .bout   (blk_bout_s),
        .bypass (blk_bypass_s)
    );

    // Handshake flags come straight from the state register, never from in_valid/out_ready
    assign in_ready   = (state_r == IDLE);
    assign out_valid  = (state_r == DONE);
    assign Diff       = diff_r;
    assign Bout       = bout_r;
    assign Bypass_cnt = bypass_cnt_r;

    // Control FSM plus operand, result, index and running-borrow registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            a_r          <= '0;
            b_r          <= '0;
            borrow_r     <= 1'b0;
            idx_r        <= '0;
            diff_r       <= '0;
            bout_r       <= 1'b0;
            bypass_cnt_r <= '0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid) begin
                        a_r          <= A;
                        b_r          <= B;
                        borrow_r     <= Bin;
                        idx_r        <= '0;
                        diff_r       <= '0;
                        bypass_cnt_r <= '0;
                        state_r      <= RUN;
                    end else begin
                        state_r      <= IDLE;
                    end
                end
                RUN: begin
                    diff_r[int'(idx_r) * BLOCK_SIZE +: BLOCK_SIZE] <= d_slice_s;
                    borrow_r <= blk_bout_s;
                    if (blk_bypass_s) begin
                        bypass_cnt_r <= bypass_cnt_r + CW'(1'b1);
                    end else begin
                        bypass_cnt_r <= bypass_cnt_r;
                    end
                    if (idx_r == LAST_BLK) begin
                        bout_r  <= blk_bout_s;
                        state_r <= DONE;
                    end else begin
                        idx_r   <= idx_r + CW'(1'b1);
                        state_r <= RUN;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r <= IDLE;
                    end else begin
                        state_r <= DONE;
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule
